scan_program_loader: RTL and testbench

SCAN_PROGRAM_LOADER -- requirements
Module: scan_program_loader

---
 rtl/scan_program_loader.sv | 126 ++++++++++++
 tb/tb_scan_program_loader.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_program_loader.sv
`default_nettype none
// scan_program_loader -- streams bytes LSB-first into a processor scan chain, reads the chain back, gates the processor.
// Revision 1.0
module scan_program_loader #(
  parameter int CHAIN_LEN = 2120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       scan_enable,
  output logic       scan_in,
  input  logic       chain_so,
  output logic [7:0] rd_byte,
  output logic       rd_valid,
  output logic       proc_en,
  input  logic       halt,
  output logic       busy,
  output logic       done,
  output logic       halted
);

  localparam int            CW         = $clog2(CHAIN_LEN + 1);
  localparam logic [CW-1:0] c_LAST_BIT = CW'(CHAIN_LEN - 1);

  localparam logic [2:0] c_IDLE      = 3'd0;
  localparam logic [2:0] c_WAIT_BYTE = 3'd1;
  localparam logic [2:0] c_SHIFT     = 3'd2;
  localparam logic [2:0] c_RUN       = 3'd3;
  localparam logic [2:0] c_HALTED    = 3'd4;

  logic [2:0]    r_state;
  logic [CW-1:0] r_bit_cnt;
  logic [7:0]    r_shreg;
  logic [7:0]    r_rd_asm;
  logic [7:0]    r_rd_byte;
  logic          r_rd_valid;
  logic          r_done;

  logic          w_last_bit;
  logic          w_byte_end;
  logic          w_in_shift;
  logic [7:0]    w_rd_next;

  // Byte boundaries always fall on multiples of 8 in bit_cnt, so its low bits index the readback byte.
  always_comb begin
    w_rd_next                   = r_rd_asm;
    w_rd_next[r_bit_cnt[2:0]]   = chain_so;
  end

  assign w_last_bit  = (r_bit_cnt == c_LAST_BIT);
  assign w_byte_end  = (r_bit_cnt[2:0] == 3'd7);
  assign w_in_shift  = (r_state == c_SHIFT);

  assign byte_ready  = (r_state == c_WAIT_BYTE);
  assign scan_enable = w_in_shift;
  assign scan_in     = w_in_shift & r_shreg[0];
  assign busy        = (r_state == c_WAIT_BYTE) | w_in_shift;
  assign halted      = (r_state == c_HALTED);
  assign proc_en     = (r_state == c_RUN) & ~start;
  assign rd_byte     = r_rd_byte;
  assign rd_valid    = r_rd_valid;
  assign done        = r_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= c_IDLE;
      r_bit_cnt  <= '0;
      r_shreg    <= '0;
      r_rd_asm   <= '0;
      r_rd_byte  <= '0;
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        c_IDLE, c_HALTED, c_RUN: begin
          if (start) begin
            r_state   <= c_WAIT_BYTE;
            r_bit_cnt <= '0;
            r_rd_asm  <= '0;
          end else if (halt && r_state == c_RUN) begin
            r_state <= c_HALTED;
          end
        end
        c_WAIT_BYTE: begin
          if (abort) begin
            r_state <= c_IDLE;
          end else if (byte_valid) begin
            r_shreg <= byte_in;
            r_state <= c_SHIFT;
          end
        end
        c_SHIFT: begin
          if (abort) begin
            r_state <= c_IDLE;
          end else begin
            r_shreg   <= {1'b0, r_shreg[7:1]};
            r_bit_cnt <= r_bit_cnt + CW'(1);
            // A short final byte is published zero-padded, together with done.
            if (w_byte_end || w_last_bit) begin
              r_rd_byte  <= w_rd_next;
              r_rd_valid <= 1'b1;
              r_rd_asm   <= '0;
            end else begin
              r_rd_asm <= w_rd_next;
            end
            if (w_last_bit) begin
              r_state <= c_RUN;
              r_done  <= 1'b1;
            end else if (w_byte_end) begin
              r_state <= c_WAIT_BYTE;
            end
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_scan_program_loader.sv
`default_nettype none
// tb_scan_program_loader -- scoreboard bench driving a 12-bit and a 16-bit chain instance through one shared stimulus port.
// Revision 1.0
module tb_scan_program_loader;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       chain_so;
  logic       halt;
  bit         sel;

  logic [1:0] w_start_v;
  logic [1:0] w_halt_v;
  logic [1:0] br_v, se_v, si_v, rv_v, pe_v, busy_v, done_v, halted_v;
  logic [7:0] rdb_v [2];

  logic       byte_ready, scan_enable, scan_in, rd_valid, proc_en, busy, done, halted;
  logic [7:0] rd_byte;

  assign w_start_v = {start & sel, start & ~sel};
  assign w_halt_v  = {halt & sel, halt & ~sel};

  assign byte_ready  = br_v[sel];
  assign scan_enable = se_v[sel];
  assign scan_in     = si_v[sel];
  assign rd_valid    = rv_v[sel];
  assign proc_en     = pe_v[sel];
  assign busy        = busy_v[sel];
  assign done        = done_v[sel];
  assign halted      = halted_v[sel];
  assign rd_byte     = rdb_v[sel];

  scan_program_loader #(.CHAIN_LEN(12)) u_dut12 (
    .clk(clk), .rst(rst), .start(w_start_v[0]), .abort(abort),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(br_v[0]),
    .scan_enable(se_v[0]), .scan_in(si_v[0]), .chain_so(chain_so),
    .rd_byte(rdb_v[0]), .rd_valid(rv_v[0]), .proc_en(pe_v[0]), .halt(w_halt_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .halted(halted_v[0])
  );

  scan_program_loader #(.CHAIN_LEN(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(w_start_v[1]), .abort(abort),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(br_v[1]),
    .scan_enable(se_v[1]), .scan_in(si_v[1]), .chain_so(chain_so),
    .rd_byte(rdb_v[1]), .rd_valid(rv_v[1]), .proc_en(pe_v[1]), .halt(w_halt_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .halted(halted_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   se_cnt   = 0;
  int   done_cnt = 0;
  int   exp_done = 0;
  bit   in_run [2];
  bit   q_scan [$];
  bit   q_so   [$];
  logic [7:0] q_rd [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int chain_len();
    return sel ? 16 : 12;
  endfunction

  // Reference: scan_in is the byte stream LSB-first truncated to the chain; readback is chain_so grouped by 8, zero-padded.
  task automatic model_push(input logic [7:0] b0, input logic [7:0] b1, input logic [15:0] so, input int len);
    logic [15:0] data;
    logic [7:0]  v;
    data = {b1, b0};
    for (int i = 0; i < len; i++) begin
      q_scan.push_back(data[i]);
      q_so.push_back(so[i]);
    end
    for (int g = 0; g < (len + 7) / 8; g++) begin
      v = 8'h00;
      for (int j = 0; j < 8; j++)
        if (g * 8 + j < len) v[j] = so[g * 8 + j];
      q_rd.push_back(v);
    end
  endtask

  // Readback source: supplies the next queued chain bit during each shift cycle.
  always @(posedge clk) begin
    #1;
    if (scan_enable && q_so.size() > 0) chain_so = q_so.pop_front();
    else chain_so = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (rst) begin
      if (scan_enable) begin
        se_cnt++;
        if (q_scan.size() == 0) check("unexpected_shift", 32'(scan_enable), 32'd0);
        else check("scan_in", 32'(scan_in), 32'(q_scan.pop_front()));
      end
      if (rd_valid) begin
        if (q_rd.size() == 0) check("unexpected_rd_valid", 32'(rd_valid), 32'd0);
        else check("rd_byte", 32'(rd_byte), 32'(q_rd.pop_front()));
      end
      if (done) begin
        done_cnt++;
        check("se_cycles_per_load", 32'(se_cnt), 32'(chain_len()));
        check("proc_en_at_done", 32'(proc_en), 32'd1);
        check("rd_valid_with_done", 32'(rd_valid), 32'd1);
        check("scan_bits_left_at_done", 32'(q_scan.size()), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    if (in_run[sel]) begin
      #1;
      check("proc_en_drop_on_reload", 32'(proc_en), 32'd0);
    end
    tick();
    start = 1'b0;
    check("byte_ready_after_start", 32'(byte_ready), 32'd1);
    check("busy_after_start", 32'(busy), 32'd1);
    check("halted_after_start", 32'(halted), 32'd0);
    se_cnt = 0;
    in_run[sel] = 1'b0;
  endtask

  task automatic wait_accept();
    bit acc;
    int t;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 100) begin
      @(negedge clk);
      acc = byte_ready;
      tick();
      t++;
    end
    check("byte_accepted", 32'(acc), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    if (gap > 0) begin
      byte_valid = 1'b0;
      repeat (gap) tick();
    end
    byte_in    = b;
    byte_valid = 1'b1;
    wait_accept();
  endtask

  task automatic run_load(input logic [7:0] b0, input logic [7:0] b1, input bit hold, input int gapmax);
    int t;
    exp_done++;
    do_start();
    send_byte(b0, hold ? 0 : int'($urandom_range(0, gapmax)));
    if (!hold) byte_valid = 1'b0;
    send_byte(b1, hold ? 0 : int'($urandom_range(0, gapmax)));
    byte_valid = 1'b0;
    t = 0;
    while (done_cnt != exp_done && t < 60) begin
      tick();
      t++;
    end
    check("done_seen", 32'(done_cnt), 32'(exp_done));
    in_run[sel] = 1'b1;
  endtask

  task automatic do_halt();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("proc_en_after_halt", 32'(proc_en), 32'd0);
    check("halted_after_halt", 32'(halted), 32'd1);
    check("busy_after_halt", 32'(busy), 32'd0);
    in_run[sel] = 1'b0;
  endtask

  function automatic logic [31:0] all_outputs();
    return {4'h0, br_v, se_v, si_v, rv_v, pe_v, busy_v, done_v, halted_v, rdb_v[0], rdb_v[1]};
  endfunction

  task automatic directed_basic();
    logic [11:0] exp_si;
    logic [11:0] so_dir;
    exp_si = 12'b0011_1010_0101;
    so_dir = 12'b0101_1100_0011;
    for (int i = 0; i < 12; i++) begin
      q_scan.push_back(exp_si[i]);
      q_so.push_back(so_dir[i]);
    end
    q_rd.push_back(8'hC3);
    q_rd.push_back(8'h05);
    run_load(8'hA5, 8'h03, 1'b0, 2);
    check("proc_en_in_run", 32'(proc_en), 32'd1);
    check("scan_enable_in_run", 32'(scan_enable), 32'd0);
  endtask

  initial begin
    logic [7:0]  rb0, rb1;
    logic [15:0] rso;
    int          dc, qs;

    rst = 1'b0; start = 1'b0; abort = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
    chain_so = 1'b0; halt = 1'b0; sel = 1'b0;
    in_run[0] = 1'b0; in_run[1] = 1'b0;
    #2;
    check("reset_outputs_zero", all_outputs(), 32'd0);
    #10;
    rst = 1'b1;
    tick();
    check("idle_byte_ready", 32'(byte_ready), 32'd0);

    // Basic load and readback on the 12-bit chain.
    directed_basic();

    // Halt, then reload straight into WAIT_BYTE.
    do_halt();
    do_start();

    // Abort on the same cycle a byte would be accepted.
    byte_in = 8'hFF; byte_valid = 1'b1; abort = 1'b1;
    tick();
    abort = 1'b0; byte_valid = 1'b0;
    check("abort_accept_byte_ready", 32'(byte_ready), 32'd0);
    check("abort_accept_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    check("abort_accept_no_shift", 32'(scan_enable), 32'd0);

    // Back-pressure on the 16-bit chain: second byte held valid through the first burst.
    sel = 1'b1;
    rb0 = 8'h3C; rb1 = 8'hD9; rso = 16'hA36E;
    model_push(rb0, rb1, rso, 16);
    run_load(rb0, rb1, 1'b1, 0);

    // Abort in the 5th shift cycle of the first byte.
    sel = 1'b0;
    do_start();
    rb0 = 8'($urandom);
    for (int i = 0; i < 5; i++) begin
      q_scan.push_back(rb0[i]);
      q_so.push_back(1'b1);
    end
    byte_in = rb0; byte_valid = 1'b1;
    wait_accept();
    byte_valid = 1'b0;
    repeat (4) tick();
    dc = done_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_shift_scan_enable", 32'(scan_enable), 32'd0);
    check("abort_shift_busy", 32'(busy), 32'd0);
    repeat (4) tick();
    check("abort_no_done", 32'(done_cnt), 32'(dc));
    check("abort_bits_shifted", 32'(q_scan.size()), 32'd0);
    q_so.delete();

    // Asynchronous reset in the 3rd shift cycle.
    do_start();
    rb0 = 8'($urandom);
    q_scan.push_back(rb0[0]);
    q_scan.push_back(rb0[1]);
    byte_in = rb0; byte_valid = 1'b1;
    wait_accept();
    byte_valid = 1'b0;
    tick();
    tick();
    #1;
    rst = 1'b0;
    #1;
    check("async_reset_outputs_zero", all_outputs(), 32'd0);
    qs = q_scan.size();
    check("reset_partial_bits", 32'(qs), 32'd0);
    q_scan.delete(); q_so.delete(); q_rd.delete();
    tick();
    #2;
    rst = 1'b1;
    in_run[0] = 1'b0; in_run[1] = 1'b0;
    tick();
    directed_basic();

    // Randomised loads across both chain lengths.
    for (int it = 0; it < 12; it++) begin
      sel = 1'($urandom_range(0, 1));
      rb0 = 8'($urandom);
      rb1 = 8'($urandom);
      rso = 16'($urandom);
      model_push(rb0, rb1, rso, chain_len());
      run_load(rb0, rb1, 1'($urandom_range(0, 1)), 12);
      if ($urandom_range(0, 1) == 1) do_halt();
    end

    repeat (3) tick();
    check("final_rd_queue_empty", 32'(q_rd.size()), 32'd0);
    check("final_scan_queue_empty", 32'(q_scan.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
